// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam logic [3:0]  WSTRB_READ   = 4'b0000;
  localparam logic [31:0] ILLEGAL_WORD = 32'h0000_0000;
  localparam int unsigned WdWidth      = 8;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Winner selection between fetch and data requests.
// MEM_ARBITER_RR_EN selects round-robin (with its pointer flop); otherwise data beats fetch.
module mem_arbiter_pick
  import mem_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_valid,
  input  logic   d_valid,
  input  logic   take,
  output logic   grant,
  output owner_e owner
);

  assign grant = i_valid | d_valid;

`ifdef MEM_ARBITER_RR_EN
  // ptr_q names the port favoured on the next tie.
  owner_e ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= OWN_I;
    end else if (take) begin
      ptr_q <= (owner == OWN_D) ? OWN_I : OWN_D;
    end
  end

  always_comb begin
    owner = OWN_I;
    if (i_valid && d_valid) begin
      owner = ptr_q;
    end else if (d_valid) begin
      owner = OWN_D;
    end
  end
`else
  logic unused_rr;
  assign unused_rr = clk ^ rst ^ take;

  always_comb begin
    owner = d_valid ? OWN_D : OWN_I;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port RAM, with access watchdog.
// Optional round-robin arbitration via MEM_ARBITER_RR_EN (see mem_arbiter_pick).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 20,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_ready,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_valid,
  input  logic [3:0]            d_wstrb,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ready,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_valid,
  output logic [3:0]            mem_wstrb,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  err
);

  localparam logic [WdWidth-1:0] TimeoutVal = WdWidth'(TIMEOUT_CYCLES);

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic                  mvalid_q, mvalid_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  i_ready_q, i_ready_d;
  logic                  d_ready_q, d_ready_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  err_q, err_d;
  logic [WdWidth-1:0]    wd_q, wd_d;

  logic                  pick_grant;
  owner_e                pick_owner;
  logic                  take;
  logic                  finish;
  logic                  fail;
  logic [DATA_WIDTH-1:0] resp;

  mem_arbiter_pick u_pick (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .d_valid (d_valid),
    .take    (take),
    .grant   (pick_grant),
    .owner   (pick_owner)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    mvalid_d  = mvalid_q;
    wstrb_d   = wstrb_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_ready_d = i_ready_q;
    d_ready_d = d_ready_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    err_d     = err_q;
    wd_d      = wd_q;
    take      = 1'b0;
    finish    = 1'b0;
    fail      = 1'b0;
    resp      = mem_rdata;

    case (state_q)
      StIdle: begin
        if (pick_grant) begin
          take     = 1'b1;
          owner_d  = pick_owner;
          mvalid_d = 1'b1;
          wd_d     = '0;
          state_d  = StBusy;
          if (pick_owner == OWN_D) begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
            wstrb_d = d_wstrb;
          end else begin
            addr_d  = i_addr;
            wdata_d = '0;
            wstrb_d = WSTRB_READ;
          end
        end
      end
      StBusy: begin
        if (mem_ready) begin
          finish = 1'b1;
        end else if (wd_q == TimeoutVal) begin
          finish = 1'b1;
          fail   = 1'b1;
          resp   = DATA_WIDTH'(ILLEGAL_WORD);
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StResp: begin
        // No grant here: a still-asserted valid waits for the next IDLE.
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;
        err_d     = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (finish) begin
      mvalid_d = 1'b0;
      err_d    = fail;
      state_d  = StResp;
      if (owner_q == OWN_D) begin
        d_ready_d = 1'b1;
        d_rdata_d = resp;
      end else begin
        i_ready_d = 1'b1;
        i_rdata_d = resp;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_q   <= OWN_I;
      mvalid_q  <= 1'b0;
      wstrb_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      err_q     <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      mvalid_q  <= mvalid_d;
      wstrb_q   <= wstrb_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      err_q     <= err_d;
      wd_q      <= wd_d;
    end
  end

  assign mem_valid = mvalid_q;
  assign mem_wstrb = wstrb_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle table plus timeout, reset and back-to-back sequences.
module tb_mem_arbiter;

`ifdef MEM_ARBITER_RR_EN
  localparam bit Rr = 1'b1;
`else
  localparam bit Rr = 1'b0;
`endif

  localparam logic [19:0] A  = 20'h00010;
  localparam logic [19:0] B  = 20'h00040;
  localparam logic [31:0] IW = 32'h0050_0093;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;
  localparam logic [31:0] BF = 32'h0000_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, d_valid;
  logic [19:0] i_addr, d_addr;
  logic [3:0]  d_wstrb;
  logic [31:0] d_wdata;
  logic        i_ready, d_ready, err;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_valid, mem_ready;
  logic [3:0]  mem_wstrb;
  logic [19:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic        stall;
  logic        preload;
  logic [31:0] ram [256];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (20),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .i_addr    (i_addr),
    .i_ready   (i_ready),
    .i_rdata   (i_rdata),
    .d_valid   (d_valid),
    .d_wstrb   (d_wstrb),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ready   (d_ready),
    .d_rdata   (d_rdata),
    .mem_valid (mem_valid),
    .mem_wstrb (mem_wstrb),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .err       (err)
  );

  // Combinational RAM model: returns the pre-write word, writes on the accepting edge.
  assign mem_ready = mem_valid && !stall;
  assign mem_rdata = ram[mem_addr[7:0]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
      ram[8'h10] <= IW;
    end else if (mem_valid && mem_ready) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wstrb[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        iv;
    logic        dv;
    logic [3:0]  ws;
    logic [19:0] da;
    logic [31:0] wd;
    logic        mv;
    logic [19:0] ma;
    logic [3:0]  mws;
    logic [31:0] mwd;
    logic        ir;
    logic [31:0] ird;
    logic        dr;
    logic [31:0] drd;
    logic        er;
  } vec_t;

  function automatic vec_t mk(logic iv, logic dv, logic [3:0] ws, logic [19:0] da,
                              logic [31:0] wd, logic mv, logic [19:0] ma, logic [3:0] mws,
                              logic [31:0] mwd, logic ir, logic [31:0] ird, logic dr,
                              logic [31:0] drd);
    vec_t v;
    v.iv = iv;  v.dv = dv;   v.ws = ws;   v.da = da;   v.wd = wd;
    v.mv = mv;  v.ma = ma;   v.mws = mws; v.mwd = mwd;
    v.ir = ir;  v.ird = ird; v.dr = dr;   v.drd = drd; v.er = 1'b0;
    return v;
  endfunction

  vec_t tbl [16];

  initial begin
    // Inputs are applied before an edge; outputs compared after it.
    tbl[0]  = mk(1, 0, 4'h0, 20'h0, 32'h0, 1, A, 4'h0, 32'h0, 0, 32'h0, 0, 32'h0);
    tbl[1]  = mk(1, 0, 4'h0, 20'h0, 32'h0, 0, A, 4'h0, 32'h0, 1, IW,    0, 32'h0);
    tbl[2]  = mk(1, 0, 4'h0, 20'h0, 32'h0, 0, A, 4'h0, 32'h0, 0, IW,    0, 32'h0);
    tbl[3]  = mk(0, 0, 4'h0, 20'h0, 32'h0, 0, A, 4'h0, 32'h0, 0, IW,    0, 32'h0);
    tbl[4]  = mk(0, 1, 4'h3, B,     DB,    1, B, 4'h3, DB,    0, IW,    0, 32'h0);
    tbl[5]  = mk(0, 1, 4'h3, B,     DB,    0, B, 4'h3, DB,    0, IW,    1, 32'h0);
    tbl[6]  = mk(0, 1, 4'h3, B,     DB,    0, B, 4'h3, DB,    0, IW,    0, 32'h0);
    tbl[7]  = mk(0, 1, 4'h0, B,     32'h0, 1, B, 4'h0, 32'h0, 0, IW,    0, 32'h0);
    tbl[8]  = mk(0, 1, 4'h0, B,     32'h0, 0, B, 4'h0, 32'h0, 0, IW,    1, BF);
    tbl[9]  = mk(0, 0, 4'h0, B,     32'h0, 0, B, 4'h0, 32'h0, 0, IW,    0, BF);
    // Tie: fixed priority serves data first; round-robin (last grant data) serves fetch first.
    tbl[10] = mk(1, 1, 4'h0, B, 32'h0, 1, Rr ? A : B, 4'h0, 32'h0, 0,   IW, 0,   BF);
    tbl[11] = mk(1, 1, 4'h0, B, 32'h0, 0, Rr ? A : B, 4'h0, 32'h0, Rr,  IW, !Rr, BF);
    tbl[12] = mk(!Rr, Rr, 4'h0, B, 32'h0, 0, Rr ? A : B, 4'h0, 32'h0, 0, IW, 0,  BF);
    tbl[13] = mk(!Rr, Rr, 4'h0, B, 32'h0, 1, Rr ? B : A, 4'h0, 32'h0, 0, IW, 0,  BF);
    tbl[14] = mk(!Rr, Rr, 4'h0, B, 32'h0, 0, Rr ? B : A, 4'h0, 32'h0, !Rr, IW, Rr, BF);
    tbl[15] = mk(0, 0, 4'h0, B, 32'h0, 0, Rr ? B : A, 4'h0, 32'h0, 0,   IW, 0,   BF);

    rst = 1'b1; preload = 1'b1; stall = 1'b0;
    i_valid = 1'b0; i_addr = A; d_valid = 1'b0; d_addr = 20'h0; d_wstrb = 4'h0; d_wdata = 32'h0;
    #1;
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_mem_wdata", mem_wdata,      32'd0);
    check("rst_readies",   32'({i_ready, d_ready, err}), 32'd0);
    check("rst_rdata",     i_rdata | d_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0; preload = 1'b0;

    for (int k = 0; k < 16; k++) begin
      i_valid = tbl[k].iv; d_valid = tbl[k].dv; d_wstrb = tbl[k].ws;
      d_addr  = tbl[k].da; d_wdata = tbl[k].wd;
      @(negedge clk);
      check($sformatf("v%0d_mem_valid", k), 32'(mem_valid), 32'(tbl[k].mv));
      check($sformatf("v%0d_mem_addr",  k), 32'(mem_addr),  32'(tbl[k].ma));
      check($sformatf("v%0d_mem_wstrb", k), 32'(mem_wstrb), 32'(tbl[k].mws));
      check($sformatf("v%0d_mem_wdata", k), mem_wdata,      tbl[k].mwd);
      check($sformatf("v%0d_i_ready",   k), 32'(i_ready),   32'(tbl[k].ir));
      check($sformatf("v%0d_i_rdata",   k), i_rdata,        tbl[k].ird);
      check($sformatf("v%0d_d_ready",   k), 32'(d_ready),   32'(tbl[k].dr));
      check($sformatf("v%0d_d_rdata",   k), d_rdata,        tbl[k].drd);
      check($sformatf("v%0d_err",       k), 32'(err),       32'(tbl[k].er));
    end

    // Watchdog: RAM never ready, TIMEOUT_CYCLES=4 -> error response after the 6th edge.
    stall = 1'b1; d_valid = 1'b1; d_addr = B; d_wstrb = 4'h0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 5) begin
        check($sformatf("to%0d_mem_valid", k), 32'(mem_valid), 32'd1);
        check($sformatf("to%0d_d_ready", k),   32'(d_ready),   32'd0);
      end else begin
        check("to_d_ready",   32'(d_ready),   32'd1);
        check("to_err",       32'(err),       32'd1);
        check("to_d_rdata",   d_rdata,        32'h0);
        check("to_mem_valid", 32'(mem_valid), 32'd0);
      end
    end
    d_valid = 1'b0; stall = 1'b0;
    @(negedge clk);
    check("to_after_err",     32'(err),     32'd0);
    check("to_after_d_ready", 32'(d_ready), 32'd0);

    // Asynchronous reset while the access is in flight.
    i_valid = 1'b1; i_addr = A;
    @(posedge clk); #1;
    check("rb_mem_valid_up", 32'(mem_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rb_mem_valid_down", 32'(mem_valid), 32'd0);
    check("rb_mem_addr",       32'(mem_addr),  32'd0);
    @(negedge clk); i_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rb%0d_no_ready", k), 32'({i_ready, d_ready, err}), 32'd0);
    end

    // Continuous fetch requests: grant every third cycle, never overlapping RESP.
    i_valid = 1'b1; i_addr = A;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check($sformatf("bb%0d_mem_valid", k), 32'(mem_valid), 32'((k % 3) == 0));
      check($sformatf("bb%0d_i_ready", k),   32'(i_ready),   32'((k % 3) == 1));
      if ((k % 3) == 1) check($sformatf("bb%0d_i_rdata", k), i_rdata, IW);
    end
    i_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
